// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider placed beside the ALU in the DataPath.
//   Dividend (from Y) and divisor (from the bus) are captured on an accepted
//   start pulse. One quotient bit is produced per clock; the quotient goes to
//   LO and the remainder to HI. A one-cycle done pulse lets the control
//   sequencer stall its T-steps until the result is ready.
//
//   Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//     defined   : two's-complement operands, truncation toward zero
//     undefined : unsigned operands, no sign logic
//
// Ports
//   clock        in   rising-edge clock
//   clear        in   asynchronous active-low reset
//   start        in   request, sampled only while idle
//   dividend     in   [WIDTH] numerator, captured on accepted start
//   divisor      in   [WIDTH] denominator, captured on accepted start
//   busy         out  high from the edge after accept until done
//   done         out  single-cycle result-valid pulse
//   quotient     out  [WIDTH] result for LO, held until next done
//   remainder    out  [WIDTH] result for HI, held until next done
//   div_by_zero  out  divide-by-zero flag for the held result
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] part_rem;   // partial remainder; always < divisor between steps
    logic [WIDTH-1:0] work_q;     // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;
    logic             dbz_w;

    logic             load_en;
    logic             step_en;
    logic             finish_en;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
    logic             neg_q;
    logic             neg_r;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FINISH : ITER;
                end
            end
            ITER: begin
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath enables
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state != IDLE);
        load_en   = (state == IDLE) && start;
        step_en   = (state == ITER);
        finish_en = (state == FINISH);
    end

    // ------------------------------------------------------------------
    // Operand magnitudes, restoring step and result sign correction
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_neg = dividend[WIDTH-1];
        b_neg = divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
`else
        a_mag = dividend;
        b_mag = divisor;
`endif
        shifted = {part_rem, work_q[WIDTH-1]};
        // trial[WIDTH] set means the subtraction went negative: restore.
        trial   = shifted - {1'b0, dvsr};

`ifdef SEQ_DIVIDER_SIGNED_EN
        q_final = neg_q ? (~work_q + 1'b1) : work_q;
        r_final = neg_r ? (~part_rem + 1'b1) : part_rem;
`else
        q_final = work_q;
        r_final = part_rem;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            part_rem    <= '0;
            work_q      <= '0;
            dvsr        <= '0;
            count       <= '0;
            dbz_w       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= finish_en;

            if (load_en) begin
                dvsr     <= b_mag;
                part_rem <= '0;
                count    <= '0;
                dbz_w    <= (divisor == '0);
                // On divide-by-zero the raw dividend is parked here so it can
                // be returned unmodified as the remainder.
                work_q   <= (divisor == '0) ? dividend : a_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
`endif
            end

            if (step_en) begin
                part_rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                work_q   <= {work_q[WIDTH-2:0], ~trial[WIDTH]};
                count    <= count + 1'b1;
            end

            if (finish_en) begin
                if (dbz_w) begin
                    quotient    <= '1;
                    remainder   <= work_q;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= q_final;
                    remainder   <= r_final;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    logic         clock;
    logic         clear;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    seq_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the mathematical values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Present operands and raise start; call at a negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    // Wait for the accepting edge, then follow the operation to its done
    // pulse. inj_at>0 pulses start with other operands mid-operation.
    // Returns at the negedge where done is high.
    task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int inj_at, input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        int           exp_lat;
        model(a, b, eq, er, ez);
        exp_lat = (b == 0) ? 1 : W + 1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("busy_after_accept", W'(busy), W'(1));
        check("done_after_accept", W'(done), W'(0));
        lat = 0;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (start) start = 1'b0;
            if (inj_at > 0 && lat == inj_at) begin
                issue(ia, ib);
            end
            if (lat == 2 && !done) begin
                check("held_quotient", quotient, prev_q);
                check("held_remainder", remainder, prev_r);
            end
            if (done) break;
        end
        start = 1'b0;
        check("latency", W'(lat), W'(exp_lat));
        check("busy_at_done", W'(busy), W'(0));
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", W'(div_by_zero), W'(ez));
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        issue(a, b);
        collect(a, b, 0, '0, '0);
        @(negedge clock);
        check("done_single_cycle", W'(done), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        clear    = 1'b0;
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        repeat (2) @(negedge clock);
        clear = 1'b1;

        // Directed cases
        run(32'h0000000E, 32'h00000003);
        run(32'h12345678, 32'h00000000);
        run(32'hFFFFFFF9, 32'h00000002);
        run(32'h80000000, 32'hFFFFFFFF);
        run(32'h00000000, 32'h00000005);
        run(32'h00000003, 32'h0000000A);
        run(32'hFFFFFFFF, 32'h00000001);
        run(32'h00000000, 32'h00000000);

        // Start while busy is ignored; then back-to-back start in the done cycle
        @(negedge clock);
        issue(32'd100, 32'd7);
        collect(32'd100, 32'd7, 9, 32'd50, 32'd5);
        issue(32'd50, 32'd5);
        collect(32'd50, 32'd5, 0, '0, '0);
        @(negedge clock);
        check("btb_done_single", W'(done), W'(0));

        // Asynchronous clear mid-operation
        @(negedge clock);
        issue(32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        repeat (2) @(negedge clock);
        clear = 1'b1;
        prev_q = '0;
        prev_r = '0;
        seen = 0;
        repeat (W + 6) begin
            @(negedge clock);
            if (done) seen++;
        end
        check("abort_no_done", W'(seen), W'(0));
        run(32'd9, 32'd4);

        // Randomized operands, biased toward small divisors and zero
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra >> $urandom_range(0, 31);
                3:       rb = $urandom | 32'h80000000;
                default: rb = $urandom;
            endcase
            run(ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
